// File: rtl/optical_8x8_cfg_sched_pkg.sv
// Shared defaults, grant width and FSM encodings for the 8x8 optical
// configuration scheduler.
package optical_8x8_cfg_sched_pkg;

  localparam int DSTWIDTH_DEF = 3;
  localparam int PORTNUM_DEF  = 8;
  localparam int GRANT_W      = 20;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARB        = 3'd1,
    ST_ISSUE      = 3'd2,
    ST_WAIT_GRANT = 3'd3,
    ST_SETTLE     = 3'd4,
    ST_HOLD       = 3'd5
  } state_e;

endpackage

// File: rtl/optical_8x8_cfg_sched_perm_arb.sv
// Combinational round-robin arbitration per destination followed by a fill
// pass that hands the unused destinations to the remaining ports, so the
// result is always a full permutation.
module optical_perm_arb #(
  parameter int P_DSTWIDTH = 3,
  parameter int P_PORTNUM  = 8,
  parameter int PTR_W      = 3
) (
  input  logic [P_PORTNUM-1:0]            i_req,
  input  logic [P_DSTWIDTH*P_PORTNUM-1:0] i_dst,
  input  logic [PTR_W-1:0]                i_rr_ptr,
  output logic [P_DSTWIDTH*P_PORTNUM-1:0] o_perm,
  output logic [P_PORTNUM-1:0]            o_win
);

  // Winners first (scan from rr_ptr per destination), then fill losers/idles
  // with the lowest unused destinations in ascending port order.
  always_comb begin
    logic [P_PORTNUM-1:0] used;
    logic                 found;
    logic                 taken;
    int                   p;
    o_perm = '0;
    o_win  = '0;
    used   = '0;
    found  = 1'b0;
    taken  = 1'b0;
    p      = 0;
    for (int d = 0; d < P_PORTNUM; d++) begin
      found = 1'b0;
      for (int k = 0; k < P_PORTNUM; k++) begin
        p = (int'(i_rr_ptr) + k) % P_PORTNUM;
        if (!found && i_req[p] &&
            i_dst[p*P_DSTWIDTH +: P_DSTWIDTH] == P_DSTWIDTH'(d)) begin
          found                              = 1'b1;
          o_win[p]                           = 1'b1;
          o_perm[p*P_DSTWIDTH +: P_DSTWIDTH] = P_DSTWIDTH'(d);
          used[d]                            = 1'b1;
        end
      end
    end
    for (int q = 0; q < P_PORTNUM; q++) begin
      if (!o_win[q]) begin
        taken = 1'b0;
        for (int d = 0; d < P_PORTNUM; d++) begin
          if (!taken && !used[d]) begin
            o_perm[q*P_DSTWIDTH +: P_DSTWIDTH] = P_DSTWIDTH'(d);
            used[d]                            = 1'b1;
            taken                              = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/optical_8x8_cfg_sched.sv
// Scheduler that captures port requests, builds a permutation for the 8x8
// controller, waits for its grant word, lets the switch settle and then holds
// the configuration while acknowledging the served ports.
module optical_8x8_cfg_sched
  import optical_8x8_cfg_sched_pkg::*;
#(
  parameter int P_DSTWIDTH = DSTWIDTH_DEF,
  parameter int P_PORTNUM  = PORTNUM_DEF,
  parameter int P_SETTLE   = 16,
  parameter int P_HOLD     = 32,
  parameter int P_TIMEOUT  = 64
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [P_PORTNUM-1:0]            i_port_req,
  input  logic [P_DSTWIDTH*P_PORTNUM-1:0] i_port_dst,
  output logic [P_DSTWIDTH*P_PORTNUM-1:0] o_8x8_req,
  output logic                            o_8x8_valid,
  input  logic [GRANT_W-1:0]              i_grant_8x8,
  input  logic                            i_grant_valid,
  output logic [GRANT_W-1:0]              o_switch_cfg,
  output logic                            o_cfg_ready,
  output logic [P_PORTNUM-1:0]            o_port_ack,
  output logic                            o_timeout
);

  localparam int CNT_MAX = (P_SETTLE > P_HOLD) ?
                           ((P_SETTLE > P_TIMEOUT) ? P_SETTLE : P_TIMEOUT) :
                           ((P_HOLD > P_TIMEOUT) ? P_HOLD : P_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PTR_W   = (P_PORTNUM > 1) ? $clog2(P_PORTNUM) : 1;
  localparam int PERM_W  = P_DSTWIDTH * P_PORTNUM;

  function automatic logic [PERM_W-1:0] identity_perm();
    logic [PERM_W-1:0] r;
    r = '0;
    for (int n = 0; n < P_PORTNUM; n++) r[n*P_DSTWIDTH +: P_DSTWIDTH] = P_DSTWIDTH'(n);
    return r;
  endfunction

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     rr_q;
  logic [P_PORTNUM-1:0] req_q;
  logic [PERM_W-1:0]    dst_q;
  logic [PERM_W-1:0]    perm_q;
  logic [P_PORTNUM-1:0] win_q;
  logic [GRANT_W-1:0]   cfg_q;
  logic [PERM_W-1:0]    arb_perm;
  logic [P_PORTNUM-1:0] arb_win;
  logic                 wait_expired;
  logic                 hold_entry;

  optical_perm_arb #(
    .P_DSTWIDTH (P_DSTWIDTH),
    .P_PORTNUM  (P_PORTNUM),
    .PTR_W      (PTR_W)
  ) u_arb (
    .i_req    (req_q),
    .i_dst    (dst_q),
    .i_rr_ptr (rr_q),
    .o_perm   (arb_perm),
    .o_win    (arb_win)
  );

  assign wait_expired = (cnt_q == CNT_W'(P_TIMEOUT - 1));
  assign hold_entry   = (state_q == ST_SETTLE) && (state_d == ST_HOLD);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and phase counter; counter restarts at 0 on every state change.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (|i_port_req) state_d = ST_ARB;
      ST_ARB:        state_d = ST_ISSUE;
      ST_ISSUE:      state_d = ST_WAIT_GRANT;
      ST_WAIT_GRANT: begin
        if (i_grant_valid)     state_d = ST_SETTLE;
        else if (wait_expired) state_d = ST_IDLE;
      end
      ST_SETTLE:     if (cnt_q == CNT_W'(P_SETTLE - 1)) state_d = ST_HOLD;
      ST_HOLD:       if (cnt_q == CNT_W'(P_HOLD - 1))   state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
    cnt_d = '0;
    if ((state_d == state_q) &&
        (state_q == ST_WAIT_GRANT || state_q == ST_SETTLE || state_q == ST_HOLD))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Outputs decoded from state; pulses are suppressed while reset is applied.
  always_comb begin
    o_8x8_valid = (state_q == ST_ISSUE);
    o_cfg_ready = (state_q == ST_HOLD);
    o_timeout   = !i_rst && (state_q == ST_WAIT_GRANT) && !i_grant_valid && wait_expired;
    o_port_ack  = (!i_rst && state_q == ST_HOLD && cnt_q == '0) ? win_q : '0;
  end

  // Datapath: request capture, registered arbitration, grant capture, pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q  <= '0;
      rr_q   <= '0;
      req_q  <= '0;
      dst_q  <= '0;
      perm_q <= identity_perm();
      win_q  <= '0;
      cfg_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == ST_IDLE) begin
        req_q <= i_port_req;
        dst_q <= i_port_dst;
      end
      if (state_q == ST_ARB) begin
        perm_q <= arb_perm;
        win_q  <= arb_win;
      end
      if (state_q == ST_WAIT_GRANT && i_grant_valid) cfg_q <= i_grant_8x8;
      if (hold_entry) rr_q <= (rr_q == PTR_W'(P_PORTNUM - 1)) ? '0 : rr_q + PTR_W'(1);
    end
  end

  assign o_8x8_req    = perm_q;
  assign o_switch_cfg = cfg_q;

endmodule

// File: tb/tb_optical_8x8_cfg_sched.sv
// Bench for optical_8x8_cfg_sched: hand-computed vector table, corner
// sequences (timeout, reset during settle) and randomized transactions
// checked against a behavioural permutation model.
module tb_optical_8x8_cfg_sched;

  localparam int DW = 3;
  localparam int PN = 8;
  localparam int GW = 20;
  localparam int SETTLE = 16;
  localparam int HOLD = 32;
  localparam int TMO = 64;
  localparam logic [23:0] IDENT = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [7:0]    i_port_req = '0;
  logic [23:0]   i_port_dst = '0;
  logic [23:0]   o_8x8_req;
  logic          o_8x8_valid;
  logic [GW-1:0] i_grant_8x8 = '0;
  logic          i_grant_valid = 1'b0;
  logic [GW-1:0] o_switch_cfg;
  logic          o_cfg_ready;
  logic [7:0]    o_port_ack;
  logic          o_timeout;

  int n_chk = 0;
  int n_fail = 0;
  int rr_exp = 0;
  logic [GW-1:0] cfg_exp = '0;

  optical_8x8_cfg_sched dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_port_req    (i_port_req),
    .i_port_dst    (i_port_dst),
    .o_8x8_req     (o_8x8_req),
    .o_8x8_valid   (o_8x8_valid),
    .i_grant_8x8   (i_grant_8x8),
    .i_grant_valid (i_grant_valid),
    .o_switch_cfg  (o_switch_cfg),
    .o_cfg_ready   (o_cfg_ready),
    .o_port_ack    (o_port_ack),
    .o_timeout     (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0]  req;
    logic [23:0] dst;
    int          gdelay;
    logic [19:0] gword;
    logic [23:0] perm;
    logic [7:0]  ack;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Behavioural model: ports claim their destination in rotating priority
  // order; unclaimed destinations are dealt out in ascending order.
  function automatic void model(input logic [7:0] req, input logic [23:0] dst, input int rr,
                                output logic [23:0] perm, output logic [7:0] win);
    bit [7:0] claimed;
    int freeq[$];
    claimed = '0;
    perm = '0;
    win = '0;
    for (int k = 0; k < PN; k++) begin
      int p;
      int d;
      p = (rr + k) % PN;
      d = int'(dst[p*DW +: DW]);
      if (req[p] && !claimed[d]) begin
        claimed[d] = 1'b1;
        win[p] = 1'b1;
        perm[p*DW +: DW] = d[2:0];
      end
    end
    for (int d = 0; d < PN; d++) if (!claimed[d]) freeq.push_back(d);
    for (int p = 0; p < PN; p++) begin
      if (!win[p]) begin
        int d;
        d = freeq.pop_front();
        perm[p*DW +: DW] = d[2:0];
      end
    end
  endfunction

  // One full transaction starting and ending in IDLE; gdelay < 0 means no grant.
  task automatic do_txn(input logic [7:0] req, input logic [23:0] dst, input int gdelay,
                        input logic [19:0] gword, input logic [23:0] eperm, input logic [7:0] eack);
    logic [7:0] ack_seen;
    i_port_req = req;
    i_port_dst = dst;
    tick();
    chk("valid_early", {31'd0, o_8x8_valid}, 32'd0);
    i_port_req = 8'($urandom);
    i_port_dst = 24'($urandom);
    tick();
    chk("valid_issue", {31'd0, o_8x8_valid}, 32'd1);
    chk("perm", {8'd0, o_8x8_req}, {8'd0, eperm});
    i_port_req = '0;
    tick();
    chk("valid_pulse", {31'd0, o_8x8_valid}, 32'd0);
    if (gdelay < 0) begin
      ack_seen = '0;
      for (int i = 0; i < TMO - 1; i++) begin
        chk("timeout_early", {31'd0, o_timeout}, 32'd0);
        ack_seen |= o_port_ack;
        tick();
      end
      chk("timeout_pulse", {31'd0, o_timeout}, 32'd1);
      ack_seen |= o_port_ack;
      tick();
      chk("timeout_end", {31'd0, o_timeout}, 32'd0);
      chk("timeout_noack", {24'd0, ack_seen}, 32'd0);
      chk("timeout_cfg", {12'd0, o_switch_cfg}, {12'd0, cfg_exp});
      chk("timeout_ready", {31'd0, o_cfg_ready}, 32'd0);
      chk("perm_held", {8'd0, o_8x8_req}, {8'd0, eperm});
      return;
    end
    for (int i = 0; i < gdelay; i++) begin
      chk("wait_notimeout", {31'd0, o_timeout}, 32'd0);
      tick();
    end
    i_grant_valid = 1'b1;
    i_grant_8x8 = gword;
    tick();
    i_grant_valid = 1'b0;
    cfg_exp = gword;
    chk("cfg_capture", {12'd0, o_switch_cfg}, {12'd0, gword});
    for (int i = 0; i < SETTLE; i++) begin
      chk("settle", {23'd0, o_cfg_ready, o_port_ack}, 32'd0);
      if (i == 3) begin
        i_grant_valid = 1'b1;
        i_grant_8x8 = ~gword;
      end
      if (i == 4) i_grant_valid = 1'b0;
      tick();
    end
    chk("hold_entry", {23'd0, o_cfg_ready, o_port_ack}, {23'd0, 1'b1, eack});
    chk("cfg_ignore", {12'd0, o_switch_cfg}, {12'd0, gword});
    rr_exp = (rr_exp + 1) % PN;
    for (int j = 1; j < HOLD; j++) begin
      tick();
      chk("hold", {23'd0, o_cfg_ready, o_port_ack}, {23'd0, 1'b1, 8'd0});
    end
    tick();
    chk("hold_done", {31'd0, o_cfg_ready}, 32'd0);
    chk("perm_held", {8'd0, o_8x8_req}, {8'd0, eperm});
  endtask

  initial begin
    logic [23:0] mperm;
    logic [7:0]  mwin;
    logic [7:0]  rq;
    logic [23:0] ds;
    logic [7:0]  acc;
    int          gd;

    tbl[0] = '{8'h01, {21'd0, 3'd5}, 2, 20'hABCDE,
               {3'd7, 3'd6, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5}, 8'h01};
    tbl[1] = '{8'hFF, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, 0, 20'h12345,
               {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, 8'hFF};
    tbl[2] = '{8'h28, 24'd0, 5, 20'h00F0F,
               {3'd7, 3'd6, 3'd5, 3'd4, 3'd0, 3'd3, 3'd2, 3'd1}, 8'h08};
    tbl[3] = '{8'h06, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd0}, 1, 20'hFFFFF,
               {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd7, 3'd0}, 8'h02};
    for (int i = 4; i < 7; i++)
      tbl[i] = '{8'h44, {3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0}, i, 20'h55555,
                 {3'd7, 3'd3, 3'd6, 3'd5, 3'd4, 3'd2, 3'd1, 3'd0}, 8'h40};
    tbl[7] = '{8'h44, {3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0}, 7, 20'hAAAAA,
               {3'd7, 3'd6, 3'd5, 3'd4, 3'd2, 3'd3, 3'd1, 3'd0}, 8'h04};

    // Reset values.
    repeat (3) tick();
    chk("rst_req", {8'd0, o_8x8_req}, {8'd0, IDENT});
    chk("rst_cfg", {12'd0, o_switch_cfg}, 32'd0);
    chk("rst_bits", {20'd0, o_8x8_valid, o_cfg_ready, o_timeout, 1'b0, o_port_ack}, 32'd0);
    i_rst = 1'b0;
    tick();

    // Vector table: rr_ptr advances 0..7 across the entries.
    for (int i = 0; i < 8; i++)
      do_txn(tbl[i].req, tbl[i].dst, tbl[i].gdelay, tbl[i].gword, tbl[i].perm, tbl[i].ack);

    // Timeout with ports 0 and 7 both -> 2 at rr_ptr 0, then the same request
    // again: port 0 must still win because the pointer did not move.
    do_txn(8'h81, {3'd2, 18'd0, 3'd2}, -1, 20'h0,
           {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd1, 3'd0, 3'd2}, 8'h00);
    do_txn(8'h81, {3'd2, 18'd0, 3'd2}, 3, 20'h13579,
           {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd1, 3'd0, 3'd2}, 8'h01);

    // Randomized transactions against the model.
    for (int n = 0; n < 20; n++) begin
      rq = 8'($urandom_range(1, 255));
      ds = 24'($urandom);
      gd = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 20));
      model(rq, ds, rr_exp, mperm, mwin);
      do_txn(rq, ds, gd, 20'($urandom), mperm, mwin);
    end

    // Force a non-zero pointer, then reset in the middle of SETTLE.
    if (rr_exp == 0) do_txn(8'h01, 24'd0, 0, 20'h1, IDENT, 8'h01);
    i_port_req = 8'h10;
    i_port_dst = 24'($urandom);
    tick();
    i_port_req = '0;
    tick();
    tick();
    i_grant_valid = 1'b1;
    i_grant_8x8 = 20'h3C3C3;
    tick();
    i_grant_valid = 1'b0;
    repeat (5) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("srst_req", {8'd0, o_8x8_req}, {8'd0, IDENT});
    chk("srst_cfg", {12'd0, o_switch_cfg}, 32'd0);
    chk("srst_bits", {20'd0, o_8x8_valid, o_cfg_ready, o_timeout, 1'b0, o_port_ack}, 32'd0);
    acc = '0;
    for (int i = 0; i < 40; i++) begin
      acc |= o_port_ack | {7'd0, o_cfg_ready};
      tick();
    end
    chk("srst_quiet", {24'd0, acc}, 32'd0);
    rr_exp = 0;
    cfg_exp = '0;
    do_txn(8'h81, {3'd2, 18'd0, 3'd2}, 4, 20'h0BEEF,
           {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd1, 3'd0, 3'd2}, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
